// File: rtl/cdb_multiport_buffer_pkg.sv
// Shared types for the multi-port CDB buffer: FU result and broadcast packets,
// physical register index, and circular-pointer arithmetic.
package cdb_multiport_buffer_pkg;

  localparam int PHYS_REG_W = 6;
  localparam int ARCH_REG_W = 5;
  localparam int DATA_W     = 32;
  localparam int ROB_IDX_W  = 5;
  localparam int BMASK_W    = 4;

  typedef logic [PHYS_REG_W-1:0] phys_reg_idx_t;
  typedef logic [BMASK_W-1:0]    bmask_t;

  localparam phys_reg_idx_t ZERO_REG = '0;

  typedef struct packed {
    phys_reg_idx_t         tag;
    logic [ARCH_REG_W-1:0] arch_tag;
    logic [DATA_W-1:0]     data;
    logic [ROB_IDX_W-1:0]  rob_idx;
    bmask_t                branch_tag;
  } ex_packet_t;

  typedef struct packed {
    phys_reg_idx_t         tag;
    logic [ARCH_REG_W-1:0] arch_tag;
    logic [DATA_W-1:0]     data;
    logic [ROB_IDX_W-1:0]  rob_idx;
    bmask_t                branch_tag;
  } cdb_packet_t;

  // depth must be a power of two
  function automatic int unsigned circ_add(input int unsigned base, input int unsigned off,
                                           input int unsigned depth);
    return (base + off) & (depth - 1);
  endfunction

  function automatic cdb_packet_t to_cdb(input ex_packet_t e);
    cdb_packet_t c;
    c.tag        = e.tag;
    c.arch_tag   = e.arch_tag;
    c.data       = e.data;
    c.rob_idx    = e.rob_idx;
    c.branch_tag = e.branch_tag;
    return c;
  endfunction

endpackage

// File: rtl/cdb_multiport_buffer_enq_compactor.sv
// Packs the accepted channels into consecutive tail slots, lowest channel first,
// so slot s receives the s-th accepted result.
module cdb_enq_compactor
  import cdb_multiport_buffer_pkg::*;
#(
  parameter int NUM_FU = 3,
  parameter int ACC_W  = $clog2(NUM_FU + 1)
) (
  input  logic [NUM_FU-1:0] accept_i,
  input  ex_packet_t        pkt_i      [NUM_FU],
  output logic [NUM_FU-1:0] slot_we_o,
  output ex_packet_t        slot_pkt_o [NUM_FU],
  output logic [ACC_W-1:0]  n_acc_o
);

  logic [ACC_W-1:0] cnt;

  always_comb begin
    slot_we_o = '0;
    cnt       = '0;
    for (int s = 0; s < NUM_FU; s++) slot_pkt_o[s] = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept_i[i]) begin
        slot_we_o[cnt]  = 1'b1;
        slot_pkt_o[cnt] = pkt_i[i];
        cnt             = cnt + 1'b1;
      end
    end
  end

  assign n_acc_o = cnt;

endmodule

// File: rtl/cdb_multiport_buffer.sv
// Circular result queue between the FU channels and NUM_CDB broadcast ports,
// with branch squash/clear applied to stored, incoming and outgoing entries.
module cdb_multiport_buffer
  import cdb_multiport_buffer_pkg::*;
#(
  parameter int NUM_FU  = 3,
  parameter int NUM_CDB = 2,
  parameter int DEPTH   = 32
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [NUM_FU-1:0]          in_valid_i,
  input  ex_packet_t                 in_packet_i [NUM_FU],
  output logic [NUM_FU-1:0]          in_ready_o,
  input  logic                       br_valid_i,
  input  logic                       br_squash_i,
  input  bmask_t                     br_mask_i,
  output cdb_packet_t                cdb_out_o   [NUM_CDB],
  output logic [NUM_CDB-1:0]         cdb_valid_o,
  output phys_reg_idx_t              next_tag_o  [NUM_CDB],
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACC_W = $clog2(NUM_FU + 1);

  cdb_packet_t      mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, deq_n;
  logic [CNT_W:0]   free_slots;
  logic             sq, clr;

  ex_packet_t       in_res   [NUM_FU];
  ex_packet_t       slot_pkt [NUM_FU];
  logic [NUM_FU-1:0] slot_we;
  logic [PTR_W-1:0] wr_idx   [NUM_FU];
  logic [ACC_W-1:0] n_acc;

  assign sq  = br_valid_i & br_squash_i;
  assign clr = br_valid_i & ~br_squash_i;

  // every cycle pops whatever is available up to the port count
  assign deq_n      = (count_q > CNT_W'(NUM_CDB)) ? CNT_W'(NUM_CDB) : count_q;
  assign free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {1'b0, deq_n};

  for (genvar i = 0; i < NUM_FU; i++) begin : g_in
    assign in_ready_o[i] = free_slots > (CNT_W+1)'(i);
    always_comb begin
      in_res[i] = in_packet_i[i];
      if (clr) in_res[i].branch_tag = in_packet_i[i].branch_tag & ~br_mask_i;
    end
    assign wr_idx[i] = PTR_W'(circ_add(int'(tail_q), i, DEPTH));
  end

  cdb_enq_compactor #(.NUM_FU(NUM_FU), .ACC_W(ACC_W)) u_compactor (
    .accept_i   (in_valid_i & in_ready_o),
    .pkt_i      (in_res),
    .slot_we_o  (slot_we),
    .slot_pkt_o (slot_pkt),
    .n_acc_o    (n_acc)
  );

  for (genvar p = 0; p < NUM_CDB; p++) begin : g_port
    logic [PTR_W-1:0] rd_idx, la_idx;
    logic             rd_kill, la_kill;
    assign rd_idx  = PTR_W'(circ_add(int'(head_q), p, DEPTH));
    assign la_idx  = PTR_W'(circ_add(int'(head_q), NUM_CDB + p, DEPTH));
    assign rd_kill = sq & |(mem_q[rd_idx].branch_tag & br_mask_i);
    assign la_kill = sq & |(mem_q[la_idx].branch_tag & br_mask_i);

    always_comb begin
      cdb_out_o[p] = mem_q[rd_idx];
      if (clr) cdb_out_o[p].branch_tag = mem_q[rd_idx].branch_tag & ~br_mask_i;
    end

    assign cdb_valid_o[p] = (CNT_W'(p) < count_q) & vld_q[rd_idx] & ~rd_kill;
    assign next_tag_o[p]  = ((CNT_W'(NUM_CDB + p) < count_q) && vld_q[la_idx] && !la_kill)
                            ? mem_q[la_idx].tag : ZERO_REG;
  end

  assign head_d  = PTR_W'(circ_add(int'(head_q), int'(deq_n), DEPTH));
  assign tail_d  = PTR_W'(circ_add(int'(tail_q), int'(n_acc), DEPTH));
  assign count_d = count_q + CNT_W'(n_acc) - deq_n;
  assign count_o = count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int j = 0; j < DEPTH; j++) begin
        if (sq && |(mem_q[j].branch_tag & br_mask_i)) vld_q[j] <= 1'b0;
        if (clr) mem_q[j].branch_tag <= mem_q[j].branch_tag & ~br_mask_i;
      end
      // new writes come last: they may land on slots popped this same cycle
      for (int s = 0; s < NUM_FU; s++) begin
        if (slot_we[s]) begin
          mem_q[wr_idx[s]] <= to_cdb(slot_pkt[s]);
          vld_q[wr_idx[s]] <= !(sq && |(slot_pkt[s].branch_tag & br_mask_i));
        end
      end
    end
  end

endmodule

// File: doc/cdb_multiport_buffer.md
Name: cdb_multiport_buffer

Overview:
- Parametrised successor to the single-broadcast CDB queue.
- Accepts completed results from NUM_FU functional-unit channels with per-channel valid/ready backpressure, buffers them in a DEPTH-entry circular queue, and broadcasts up to NUM_CDB results per cycle.
- Each broadcast port also carries an early-wakeup lookahead tag.
- Applies external branch resolution: squash matching entries, or clear the resolved bit from every surviving mask. It sits between the EX/CDB pipeline register and RS/ROB/RF/map-table consumers.

Parameters:
- NUM_FU, 3, number of input channels; channel 0 has highest enqueue priority (load unit).
- NUM_CDB, 2, broadcast ports per cycle.
- DEPTH, 32, queue entries; power of 2, DEPTH >= NUM_FU + NUM_CDB.
- BMASK_W, 4, branch-mask width (one-hot per in-flight branch).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  NUM_FU  channel i presents a result.
- in_packet  in  NUM_FU x EX_PACKET  result packets (tag, arch_tag, data, rob_idx, branch_tag, ...).
- in_ready  out  NUM_FU  channel i may enqueue this cycle.
- br_valid  in  1  a branch resolves this cycle.
- br_squash  in  1  mispredict: kill dependants.
- br_mask  in  BMASK_W  one-hot mask of the resolving branch.
- cdb_out  out  NUM_CDB x CDB_PACKET  broadcasts; port 0 is oldest.
- cdb_valid  out  NUM_CDB  port p carries a live result.
- next_tag  out  NUM_CDB x PHYS_REG_IDX  lookahead tags of the entries that broadcast next cycle; 0 (ZERO_REG) if the entry is invalid.
- count  out  clog2(DEPTH)+1  occupied entries, registered.

Behaviour:
- Reset:
  - head = tail = count = 0; all entry valid bits = 0.
  - cdb_valid = 0; next_tag = 0.
  - in_ready[i] = (i < NUM_FU), because the queue is empty and DEPTH >= NUM_FU.
- Reset mid-operation discards all contents on the next edge. No broadcast occurs in the cycle following reset.
- Ready rule:
  - in_ready[i] = (DEPTH - count + deq_n) > i, where deq_n = min(count, NUM_CDB) is this cycle's pop.
  - ready is independent of in_valid; no combinational valid-to-ready path.
- Enqueue:
  - Accepted channels are those with in_valid & in_ready, written in ascending channel order to tail, tail+1, ...; tail advances by the number accepted, modulo DEPTH.
  - Latency: a result enqueued in cycle N broadcasts no earlier than cycle N+1.
- Dequeue:
  - Port p presents entry head+p when p < count; cdb_valid[p] = entry valid after same-cycle squash gating.
  - head advances by deq_n; count_next = count + accepted - deq_n.
  - Squashed holes still consume a port slot and are broadcast as invalid. No compaction.
- Lookahead: next_tag[p] = tag of entry head+NUM_CDB+p when that entry is valid and within count; otherwise 0.
- Branch resolve, br_valid & br_squash:
  - Every stored or same-cycle incoming entry with (branch_tag & br_mask) != 0 is invalidated.
  - Outputs this cycle are gated the same way, so a killed result never broadcasts.
  - Invalidated entries keep their slots and count is unchanged.
- Branch resolve, br_valid & !br_squash: clear the br_mask bit from the branch_tag of all stored and incoming entries. Outgoing packets this cycle show the cleared mask.
- Simultaneous events: enqueue, dequeue and resolve in the same cycle are all legal. The ordering is resolve, then enqueue, then dequeue.
- Full and empty:
  - count == DEPTH gives in_ready = 0 except for slots freed by this cycle's pop.
  - count == 0 gives all cdb_valid = 0.
  - Pointers wrap modulo DEPTH.
- count never exceeds DEPTH. Any overflow is a design bug, and the bench asserts against it.

Decomposition:
- Shared package contents:
  - EX_PACKET and CDB_PACKET (extended with a branch_tag field of BMASK_W bits).
  - PHYS_REG_IDX.
  - ZERO_REG.
  - A helper function that computes the circular-index add.
- One natural sub-module, cdb_enq_compactor: maps the accepted-channel bitvector to tail offsets via a prefix-sum over in_valid & in_ready, and emits a write-enable and packet per slot.

Test Plan:
- Reset, then 3 channels valid with tags 5, 6, 7 in one cycle → next cycle cdb_valid = 11 carrying tags 5, 6 and next_tag[0] = 7; the cycle after, port 0 carries tag 7 and count ends at 0.
- Fill to count = 32 with no broadcasts blocked (hold inputs) → in_ready = 011 (2 freed slots); channel 2 stalls; tail and head wrap through index 31 → 0 with correct order.
- Entries tagged with branch_tag 0010 and 0001 queued, then br_valid = 1, br_squash = 1, br_mask = 0010 → all 0010 entries, including a same-cycle incoming one, never assert cdb_valid; the 0001 entries broadcast in order.
- br_valid = 1, br_squash = 0, br_mask = 0001 → every stored entry's branch_tag bit 0 reads 0 at broadcast; no entries lost.
- Assert reset while count = 10 → next cycle count = 0, cdb_valid = 0, and in_ready = 111.
- Single channel streaming one packet per cycle at an empty queue → steady state count = 1 with back-to-back broadcasts at 1-cycle latency and next_tag = 0.
